hms_timekeeper_set: RTL
=======================

HMS_TIMEKEEPER_SET -- requirements
Module: hms_timekeeper_set

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter DEB_CYCLES, default 2_000_000, debounce stability window in clk cycles (20 ms at 100 MHz).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_mode  input  1  raw, asynchronous mode push-button, active-high.
REQ-006 SHALL have port btn_inc  input  1  raw, asynchronous increment push-button, active-high.
REQ-007 SHALL have port second  output  6  binary seconds, 0-59.
REQ-008 SHALL have port minute  output  6  binary minutes, 0-59.
REQ-009 SHALL have port hour  output  6  binary hours, 0-23.
REQ-010 SHALL have port set_mode  output  2  state: 00 RUN, 01 SET_HR, 10 SET_MIN.
REQ-011 SHALL have port blink  output  1  2 Hz square wave while setting, for display blanking of the edited field.

Function
REQ-012 SHALL synchronise each button through a 2-flop synchroniser before any other use.
REQ-013 SHALL accept a synchronised level as debounced only after it has been stable for DEB_CYCLES consecutive cycles.
REQ-014 SHALL emit a one-cycle press pulse on each debounced 0->1 transition; releases produce no pulse.
REQ-015 SHALL derive a one-cycle 1 Hz tick from a prescaler counting 0..CLK_HZ-1; the tick is asserted on terminal count.
REQ-016 In RUN, each tick SHALL increment second.
  - second wraps 59->0 with a carry to minute.
  - minute wraps 59->0 with a carry to hour.
  - hour wraps 23->0.
  - All carries take effect in the same cycle as the tick; 23:59:59 -> 00:00:00 in one cycle.
REQ-017 The FSM SHALL sequence RUN -> SET_HR -> SET_MIN -> RUN, advancing one state per mode press.
REQ-018 In SET_HR, an inc press SHALL increment hour with 23->0 wrap and no carry.
REQ-019 In SET_MIN, an inc press SHALL increment minute with 59->0 wrap and no carry to hour.
REQ-020 In SET_HR and SET_MIN, ticks SHALL be ignored, and second and the prescaler SHALL be held.
REQ-021 On the SET_MIN -> RUN transition, second and the prescaler SHALL be cleared to 0, so the first tick occurs exactly CLK_HZ cycles later.
REQ-022 If mode and inc press in the same cycle, mode SHALL take effect and inc SHALL be discarded.
REQ-023 An inc press in RUN SHALL have no effect.
REQ-024 blink SHALL toggle every CLK_HZ/4 cycles in set states, restart at 1 on entry to SET_HR, and be 0 in RUN.
REQ-025 All outputs SHALL be registered; field updates SHALL appear on the outputs the cycle after the tick or press pulse.

Reset
REQ-026 On rst low, all state SHALL clear immediately and asynchronously, including mid-set or mid-debounce.
  - Cleared outputs: second, minute, hour and set_mode to 0; blink to 0.
  - Cleared internal state: FSM to RUN, prescaler, debounce counters and synchronisers to 0.
REQ-027 After rst deasserts, counting SHALL start from 00:00:00, with the first tick CLK_HZ cycles later.

Configuration
REQ-028 With macro AUTO_REPEAT_EN defined, holding debounced inc in a set state for CLK_HZ cycles SHALL generate repeat increments every CLK_HZ/4 cycles until release.
  - Wrap rules follow REQ-018 and REQ-019.
REQ-029 Without AUTO_REPEAT_EN, one hold SHALL produce exactly one increment, and no repeat counter logic SHALL exist.

Verification (CLK_HZ=8, DEB_CYCLES=3 unless noted)
REQ-030 Reset release, 8*60 cycles -> second=0, minute=1, hour=0; tick seen every 8 cycles.
REQ-031 Preload 23:59:59 via set mode, then one tick -> 00:00:00 in the same update cycle.
REQ-032 btn_mode glitch 2 cycles high -> no press, set_mode stays 00; 5 cycles high -> set_mode=01, blink=1.
REQ-033 In SET_HR with hour=23, one inc press -> hour=0, minute unchanged.
  - Mode press -> SET_MIN; mode press -> RUN with second=0, and the next tick arrives 8 cycles later.
REQ-034 btn_mode and btn_inc rise in the same cycle in SET_HR -> set_mode=10, hour unchanged.
  - rst asserted mid-SET_MIN -> all outputs 0 immediately.
REQ-035 With AUTO_REPEAT_EN, inc held 8+3*2 cycles in SET_MIN from minute=58 -> 58,59,0,1 sequence.
  - Without AUTO_REPEAT_EN, the same stimulus -> minute=59 only.

Source files
------------

// File: rtl/hms_timekeeper_set.sv
// Purpose: HH:MM:SS timekeeper with debounced mode/inc buttons for setting hour and minute.
// Latency: field updates appear one cycle after the 1 Hz tick or the debounced press pulse.
// Backpressure: none; button presses are free-running and ignored where meaningless.
// Optional feature: define AUTO_REPEAT_EN to auto-repeat a held inc button in set states.
module hms_timekeeper_set #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int DEB_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] second,
    output logic [5:0] minute,
    output logic [5:0] hour,
    output logic [1:0] set_mode,
    output logic       blink
);

    // Blink half-period; clamped so tiny CLK_HZ values still produce a valid counter.
    localparam int BLINK_HALF = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int PRE_W      = ($clog2(CLK_HZ) > 0) ? $clog2(CLK_HZ) : 1;
    localparam int DEB_W      = ($clog2(DEB_CYCLES + 1) > 0) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int BLK_W      = ($clog2(BLINK_HALF + 1) > 0) ? $clog2(BLINK_HALF + 1) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    state_t           r_state;
    logic [PRE_W-1:0] r_presc;
    logic [BLK_W-1:0] r_blk_cnt;

    // Index 0 is the mode button, index 1 the inc button.
    logic [1:0]       w_btn_raw;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_deb;
    logic [1:0]       r_press;
    logic [DEB_W-1:0] r_deb_cnt [2];

    logic             w_mode_evt;
    logic             w_inc_evt;

    assign w_btn_raw  = {btn_inc, btn_mode};
    assign w_mode_evt = r_press[0];
    assign set_mode   = r_state;

    // Two-flop synchronisers bring the raw buttons into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: a new level is accepted after DEB_CYCLES stable cycles; rising acceptance pulses r_press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_deb        <= '0;
            r_press      <= '0;
            r_deb_cnt[0] <= '0;
            r_deb_cnt[1] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (r_sync2[b] == r_deb[b]) begin
                    r_deb_cnt[b] <= '0;
                    r_press[b]   <= 1'b0;
                end else if (r_deb_cnt[b] == DEB_LAST) begin
                    r_deb_cnt[b] <= '0;
                    r_deb[b]     <= r_sync2[b];
                    r_press[b]   <= r_sync2[b];
                end else begin
                    r_deb_cnt[b] <= r_deb_cnt[b] + 1'b1;
                    r_press[b]   <= 1'b0;
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    // Holding CLK_HZ cycles arms the repeat; repeats then land every BLINK_HALF cycles.
    localparam int REP_FIRE = CLK_HZ + BLINK_HALF;
    localparam int REP_W    = $clog2(REP_FIRE + 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             w_rep_fire;

    assign w_rep_fire = r_deb[1] && (r_state != ST_RUN) && (r_rep_cnt == REP_W'(REP_FIRE));
    assign w_inc_evt  = r_press[1] | w_rep_fire;

    // Hold-time counter for inc; reloads after each repeat so the spacing stays BLINK_HALF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rep_cnt <= '0;
        end else if (!r_deb[1] || (r_state == ST_RUN)) begin
            r_rep_cnt <= '0;
        end else if (w_rep_fire) begin
            r_rep_cnt <= REP_W'(CLK_HZ + 1);
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end
`else
    assign w_inc_evt = r_press[1];
`endif

    // Mode FSM plus time fields, prescaler and blink; mode wins over a coincident inc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_RUN;
            r_presc   <= '0;
            r_blk_cnt <= '0;
            second    <= '0;
            minute    <= '0;
            hour      <= '0;
            blink     <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_blk_cnt <= '0;
                    blink     <= 1'b0;
                    if (w_mode_evt) begin
                        r_state <= ST_SET_HR;
                        blink   <= 1'b1;
                    end else if (r_presc == PRE_LAST) begin
                        r_presc <= '0;
                        if (second == 6'd59) begin
                            second <= '0;
                            if (minute == 6'd59) begin
                                minute <= '0;
                                hour   <= (hour == 6'd23) ? 6'd0 : hour + 6'd1;
                            end else begin
                                minute <= minute + 6'd1;
                            end
                        end else begin
                            second <= second + 6'd1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                ST_SET_HR: begin
                    if (r_blk_cnt == BLK_LAST) begin
                        r_blk_cnt <= '0;
                        blink     <= ~blink;
                    end else begin
                        r_blk_cnt <= r_blk_cnt + 1'b1;
                    end
                    if (w_mode_evt) begin
                        r_state <= ST_SET_MIN;
                    end else if (w_inc_evt) begin
                        hour <= (hour == 6'd23) ? 6'd0 : hour + 6'd1;
                    end
                end
                ST_SET_MIN: begin
                    if (w_mode_evt) begin
                        // Restart the second so the next tick is a full period away.
                        r_state   <= ST_RUN;
                        second    <= '0;
                        r_presc   <= '0;
                        r_blk_cnt <= '0;
                        blink     <= 1'b0;
                    end else begin
                        if (r_blk_cnt == BLK_LAST) begin
                            r_blk_cnt <= '0;
                            blink     <= ~blink;
                        end else begin
                            r_blk_cnt <= r_blk_cnt + 1'b1;
                        end
                        if (w_inc_evt) begin
                            minute <= (minute == 6'd59) ? 6'd0 : minute + 6'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
